// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// Shares one memory bus port between instruction fetch (I) and the
// memory-stage data request (D). The winner's request is latched into the
// m_* registers, issued, and its response is routed back to the owner.
// At most one transaction is outstanding at any time.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> WAIT-state watchdog of TIMEOUT_CYC cycles; on expiry the
//                owner gets rvalid with rdata=0 and bus_err pulses.
//   undefined -> WAIT lasts until m_rvalid; bus_err tied low.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   i_req/i_addr                 fetch request (held until i_ready)
//   i_ready/i_rvalid/i_rdata     fetch accept pulse, response pulse and data
//   d_req/d_addr/d_wstrb/
//   d_wdata/d_size               data request (held until d_ready)
//   d_ready/d_rvalid/d_rdata     data accept pulse, response pulse and data
//   m_req/m_addr/m_wstrb/
//   m_wdata/m_size               bus request (registered)
//   m_ack/m_rvalid/m_rdata       bus accept, response valid and data
//   busy                         FSM not in IDLE
//   bus_err                      watchdog expiry pulse
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_size,
    input  logic        m_ack,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        bus_err
);

    // msize_t encoding: access size in bytes
    localparam logic [2:0] MSIZE4 = 3'd4;

    localparam int unsigned STARVE_W =
        ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4
    } state_t;

    state_t              state;
    logic [STARVE_W-1:0] starve_cnt;
    logic                timeout;
    logic                in_wait;
    logic                d_wins;

    assign in_wait = (state == WAIT_I) || (state == WAIT_D);

    // D wins unless I has been starved for STARVE_LIMIT grants in a row
    assign d_wins = d_req && !(i_req && (starve_cnt == STARVE_W'(STARVE_LIMIT)));

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WDOG_W =
        ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [WDOG_W-1:0] wdog;

    // Fires in the TIMEOUT_CYC-th WAIT cycle; a real response takes priority
    assign timeout = in_wait && !m_rvalid && (wdog == WDOG_W'(TIMEOUT_CYC - 1));
    assign bus_err = timeout;

    // Watchdog: cleared on entry to WAIT, counts each WAIT cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wdog <= '0;
        end else if (((state == ISSUE_I) || (state == ISSUE_D)) && m_ack) begin
            wdog <= '0;
        end else if (in_wait) begin
            wdog <= wdog + WDOG_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYC only has meaning with the watchdog present
    assign bus_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    // Arbitration, request latching and transaction sequencing
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            busy       <= 1'b0;
            m_addr     <= '0;
            m_wstrb    <= '0;
            m_wdata    <= '0;
            m_size     <= MSIZE4;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state   <= ISSUE_D;
                        m_req   <= 1'b1;
                        busy    <= 1'b1;
                        m_addr  <= d_addr;
                        m_wstrb <= d_wstrb;
                        m_wdata <= d_wdata;
                        m_size  <= d_size;
                        if (!i_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + STARVE_W'(1);
                        end
                    end else if (i_req) begin
                        state      <= ISSUE_I;
                        m_req      <= 1'b1;
                        busy       <= 1'b1;
                        m_addr     <= i_addr;
                        m_wstrb    <= 4'b0000;
                        m_wdata    <= '0;
                        m_size     <= MSIZE4;
                        starve_cnt <= '0;
                    end
                end

                ISSUE_I, ISSUE_D: begin
                    // m_rvalid without m_ack is a protocol violation and ignored
                    if (m_ack) begin
                        m_req <= 1'b0;
                        if (m_rvalid) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= (state == ISSUE_I) ? WAIT_I : WAIT_D;
                        end
                    end
                end

                WAIT_I, WAIT_D: begin
                    if (m_rvalid || timeout) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Accept/response routing; rdata passes straight through from the bus
    always_comb begin
        i_ready  = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_ready  = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        case (state)
            ISSUE_I: begin
                i_ready = m_ack;
                if (m_ack && m_rvalid) begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rdata;
                end
            end
            ISSUE_D: begin
                d_ready = m_ack;
                if (m_ack && m_rvalid) begin
                    d_rvalid = 1'b1;
                    d_rdata  = m_rdata;
                end
            end
            WAIT_I: begin
                if (m_rvalid) begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rdata;
                end else if (timeout) begin
                    i_rvalid = 1'b1;
                end
            end
            WAIT_D: begin
                if (m_rvalid) begin
                    d_rvalid = 1'b1;
                    d_rdata  = m_rdata;
                end else if (timeout) begin
                    d_rvalid = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter
// Directed self-checking bench for mem_bus_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge (combinational outputs after a
// further #1), away from the rising active edge.
// ============================================================================
module tb_mem_bus_arbiter;

    localparam logic [2:0] MSIZE1 = 3'd1;
    localparam logic [2:0] MSIZE2 = 3'd2;
    localparam logic [2:0] MSIZE4 = 3'd4;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic [2:0]  m_size;
    logic        m_ack;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        busy;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ready (i_ready),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_wstrb (d_wstrb),
        .d_wdata (d_wdata),
        .d_size  (d_size),
        .d_ready (d_ready),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_wstrb (m_wstrb),
        .m_wdata (m_wdata),
        .m_size  (m_size),
        .m_ack   (m_ack),
        .m_rvalid(m_rvalid),
        .m_rdata (m_rdata),
        .busy    (busy),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_addr   = '0;
        d_wstrb  = '0;
        d_wdata  = '0;
        d_size   = MSIZE4;
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        checks++;
        if (m_size !== MSIZE4) begin errors++; $display("FAIL reset_m_size: got %0d want %0d", m_size, MSIZE4); end
        checks++;
        if ({m_addr, m_wdata, m_wstrb} !== 68'h0) begin
            errors++; $display("FAIL reset_m_fields: addr=%h wdata=%h wstrb=%h want 0", m_addr, m_wdata, m_wstrb);
        end
        checks++;
        if ({i_ready, i_rvalid, d_ready, d_rvalid, bus_err} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b want 00000", {i_ready, i_rvalid, d_ready, d_rvalid, bus_err});
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Fetch, ack in ISSUE, response two cycles after ack
    task automatic test_fetch();
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        @(negedge clk);
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0000) begin
            errors++; $display("FAIL fetch_issue: m_req=%b m_addr=%h want 1 bfc00000", m_req, m_addr);
        end
        checks++;
        if (m_size !== MSIZE4 || m_wstrb !== 4'h0 || busy !== 1'b1) begin
            errors++; $display("FAIL fetch_fields: size=%0d wstrb=%h busy=%b want 4 0 1", m_size, m_wstrb, busy);
        end
        m_ack = 1'b1;
        #1;
        checks++;
        if ({i_ready, i_rvalid, d_ready} !== 3'b100) begin
            errors++; $display("FAIL fetch_ready: {i_ready,i_rvalid,d_ready}=%b want 100", {i_ready, i_rvalid, d_ready});
        end
        @(negedge clk);
        m_ack = 1'b0;
        i_req = 1'b0;
        #1;
        checks++;
        if (m_req !== 1'b0 || i_ready !== 1'b0 || busy !== 1'b1 || i_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_wait1: m_req=%b i_ready=%b busy=%b i_rvalid=%b want 0 0 1 0", m_req, i_ready, busy, i_rvalid);
        end
        @(negedge clk);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0000_1234;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h0000_1234 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_rvalid: i_rvalid=%b i_rdata=%h d_rvalid=%b want 1 00001234 0", i_rvalid, i_rdata, d_rvalid);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
            errors++; $display("FAIL fetch_done: busy=%b i_rvalid=%b i_rdata=%h want 0 0 0", busy, i_rvalid, i_rdata);
        end
    endtask

    // Both requesting: 4 D grants, then I, then D again (counter restarted)
    task automatic test_starvation();
        i_req   = 1'b1;
        i_addr  = 32'h2000_0000;
        d_req   = 1'b1;
        d_addr  = 32'h1000_0000;
        d_wstrb = 4'h0;
        d_size  = MSIZE1;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            m_ack    = 1'b1;
            m_rvalid = 1'b1;
            m_rdata  = 32'(g);
            #1;
            checks++;
            if (g == 4) begin
                if (m_addr !== 32'h2000_0000 || i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== 32'(g)) begin
                    errors++; $display("FAIL starve_grant%0d: m_addr=%h i_ready=%b d_ready=%b i_rdata=%h want I grant", g, m_addr, i_ready, d_ready, i_rdata);
                end
            end else begin
                if (m_addr !== 32'h1000_0000 || d_ready !== 1'b1 || i_ready !== 1'b0 || d_rdata !== 32'(g)) begin
                    errors++; $display("FAIL starve_grant%0d: m_addr=%h i_ready=%b d_ready=%b d_rdata=%h want D grant", g, m_addr, i_ready, d_ready, d_rdata);
                end
            end
            @(negedge clk);
            m_ack    = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
            if (g == 5) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL starve_idle%0d: busy=%b want 0", g, busy); end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL starve_quiet: busy=%b m_req=%b want 0 0", busy, m_req);
        end
    endtask

    // Store with one idle WAIT cycle before completion
    task automatic test_store();
        d_req   = 1'b1;
        d_addr  = 32'h8000_0002;
        d_wstrb = 4'b1100;
        d_wdata = 32'hABCD_ABCD;
        d_size  = MSIZE2;
        @(negedge clk);
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h8000_0002 || m_wstrb !== 4'b1100 ||
            m_wdata !== 32'hABCD_ABCD || m_size !== MSIZE2) begin
            errors++; $display("FAIL store_fields: req=%b addr=%h wstrb=%b wdata=%h size=%0d", m_req, m_addr, m_wstrb, m_wdata, m_size);
        end
        m_ack = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_ready: d_ready=%b i_ready=%b d_rvalid=%b want 1 0 0", d_ready, i_ready, d_rvalid);
        end
        @(negedge clk);
        m_ack = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        m_rvalid = 1'b1;
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || i_ready !== 1'b0) begin
            errors++; $display("FAIL store_done: d_rvalid=%b i_rvalid=%b i_ready=%b want 1 0 0", d_rvalid, i_rvalid, i_ready);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_idle: busy=%b d_rvalid=%b want 0 0", busy, d_rvalid);
        end
    endtask

    // Stray m_rvalid in ISSUE ignored, then ack+rvalid together
    task automatic test_ack_with_rvalid();
        d_req   = 1'b1;
        d_addr  = 32'h0000_0040;
        d_wstrb = 4'h0;
        d_size  = MSIZE4;
        @(negedge clk);
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD_DEAD;
        #1;
        checks++;
        if (d_rvalid !== 1'b0 || d_ready !== 1'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL stray_rvalid: d_rvalid=%b d_ready=%b d_rdata=%h want 0 0 0", d_rvalid, d_ready, d_rdata);
        end
        @(negedge clk);
        checks++;
        if (m_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL stray_hold: m_req=%b busy=%b want 1 1", m_req, busy);
        end
        m_ack    = 1'b1;
        m_rdata  = 32'hCAFE_F00D;
        #1;
        checks++;
        if (d_ready !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL ack_rvalid: d_ready=%b d_rvalid=%b d_rdata=%h want 1 1 cafef00d", d_ready, d_rvalid, d_rdata);
        end
        @(negedge clk);
        m_ack    = 1'b0;
        m_rvalid = 1'b0;
        d_req    = 1'b0;
        checks++;
        if (busy !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL ack_rvalid_idle: busy=%b m_req=%b want 0 0", busy, m_req);
        end
        @(negedge clk);
    endtask

    // Requester withdraws during ISSUE; latched transaction still completes
    task automatic test_drop_req();
        i_req  = 1'b1;
        i_addr = 32'h0000_0100;
        @(negedge clk);
        i_req  = 1'b0;
        i_addr = 32'h0;
        @(negedge clk);
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h0000_0100) begin
            errors++; $display("FAIL drop_hold: m_req=%b m_addr=%h want 1 00000100", m_req, m_addr);
        end
        m_ack = 1'b1;
        @(negedge clk);
        m_ack    = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 32'h7777_0001;
        #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h7777_0001) begin
            errors++; $display("FAIL drop_complete: i_rvalid=%b i_rdata=%h want 1 77770001", i_rvalid, i_rdata);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // Reset asserted in WAIT_I; response arriving afterwards is dropped
    task automatic test_reset_mid();
        i_req  = 1'b1;
        i_addr = 32'h0000_0200;
        @(negedge clk);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack  = 1'b0;
        i_req  = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn   = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h5555_5555;
        #1;
        checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_rvalid: i_rvalid=%b i_rdata=%h busy=%b want 0 0 0", i_rvalid, i_rdata, busy);
        end
        checks++;
        if (m_req !== 1'b0 || m_size !== MSIZE4 || m_addr !== 32'h0 || m_wstrb !== 4'h0 || m_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_regs: req=%b size=%0d addr=%h wstrb=%h wdata=%h want reset", m_req, m_size, m_addr, m_wstrb, m_wdata);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = '0;
        checks++;
        if (busy !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: busy=%b m_req=%b want 0 0", busy, m_req);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    // Watchdog expires in the 8th WAIT cycle after ack
    task automatic test_wait_limit();
        d_req  = 1'b1;
        d_addr = 32'h0000_0300;
        @(negedge clk);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        d_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            checks++;
            if (bus_err !== (k == 8) || d_rvalid !== (k == 8) || d_rdata !== 32'h0) begin
                errors++; $display("FAIL timeout_cyc%0d: bus_err=%b d_rvalid=%b d_rdata=%h want %b %b 0", k, bus_err, d_rvalid, d_rdata, (k == 8), (k == 8));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (busy !== 1'b0 || bus_err !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL timeout_after: busy=%b bus_err=%b d_rvalid=%b want 0 0 0", busy, bus_err, d_rvalid);
        end
    endtask
`else
    // Without the watchdog WAIT holds until the bus responds
    task automatic test_wait_limit();
        d_req  = 1'b1;
        d_addr = 32'h0000_0300;
        @(negedge clk);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        d_req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || d_rvalid !== 1'b0 || bus_err !== 1'b0) begin
                errors++; $display("FAIL wait_hold%0d: busy=%b d_rvalid=%b bus_err=%b want 1 0 0", k, busy, d_rvalid, bus_err);
            end
            @(negedge clk);
        end
        m_rvalid = 1'b1;
        m_rdata  = 32'h0BAD_F00D;
        #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0BAD_F00D || bus_err !== 1'b0) begin
            errors++; $display("FAIL wait_late_resp: d_rvalid=%b d_rdata=%h bus_err=%b want 1 0badf00d 0", d_rvalid, d_rdata, bus_err);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rdata  = '0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b want 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_starvation();
        test_store();
        test_ack_with_rvalid();
        test_drop_req();
        test_reset_mid();
        test_wait_limit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
